// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// ALUOp codes (also decoded by ALUControl) and the packed strobe bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_I_WB     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_LW_WB    = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b100;
    localparam logic [2:0] ALU_LUI   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    typedef struct packed {
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic legal_opcode(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
            OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    // AND, OR, NOR, ADD, SUB, SLL, SRL
    function automatic logic legal_funct(input logic [5:0] fn);
        case (fn)
            6'b100100, 6'b100101, 6'b100111, 6'b100000,
            6'b100010, 6'b000000, 6'b000010: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_LUI:  return ALU_LUI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational strobe decode from the registered state; the instruction
// fields come straight from the IR, so they are stable for the whole instruction.
module ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              mem_ready,
    input  logic              zero,
    output logic [CTRL_W-1:0] ctrl
);

    state_t st;
    ctrl_t  c;

    assign st = state_t'(state);

    always_comb begin
        c        = '0;
        c.alu_op = ALU_ADD;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.illegal   = ~legal_opcode(opcode);
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_RTYPE;
                c.illegal   = ~legal_funct(funct);
            end
            S_R_WB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = imm_alu_op(opcode);
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                c.alu_op    = imm_alu_op(opcode);
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.ior_d    = 1'b1;
                c.mem_read = 1'b1;
            end
            S_LW_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.ior_d     = 1'b1;
                c.mem_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_SUB;
                c.pc_source = 2'b01;
                c.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                c.pc_source = 2'b10;
                c.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl = c;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main-control FSM: state register, next-state logic and the
// retired-instruction counter; strobes come from ctrl_output_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Funct,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           PCSource,
    output logic [2:0]           ALUOp,
    output logic                 Illegal,
    output logic [CNT_WIDTH-1:0] RetiredCount
);

    state_t              state, state_next;
    logic                retire;
    logic [CTRL_W-1:0]   dec_bits;
    ctrl_t               ctrl;
    logic [CNT_WIDTH-1:0] count;

    ctrl_output_decode u_decode (
        .state     (state),
        .opcode    (Opcode),
        .funct     (Funct),
        .mem_ready (MemReady),
        .zero      (Zero),
        .ctrl      (dec_bits)
    );

    // Strobes are forced quiet while reset is held, not just after it lands in FETCH.
    always_comb begin
        ctrl = ctrl_t'(dec_bits);
        if (reset) begin
            ctrl        = '0;
            ctrl.alu_op = ALU_ADD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:  if (MemReady) state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:                          state_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:  state_next = S_EXEC_I;
                    OP_LW, OP_SW:                      state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_next = S_BRANCH;
                    OP_J:                              state_next = S_JUMP;
                    default:                           state_next = S_FETCH;
                endcase
            end
            S_EXEC_R:   state_next = legal_funct(Funct) ? S_R_WB : S_FETCH;
            S_EXEC_I:   state_next = S_I_WB;
            S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (MemReady) state_next = S_LW_WB;
            S_MEM_WR: begin
                if (MemReady) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_R_WB, S_I_WB, S_LW_WB, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       count <= '0;
        else if (retire) count <= count + 1'b1;
    end

    assign PCWrite      = ctrl.pc_write;
    assign IorD         = ctrl.ior_d;
    assign MemRead      = ctrl.mem_read;
    assign MemWrite     = ctrl.mem_write;
    assign IRWrite      = ctrl.ir_write;
    assign RegDst       = ctrl.reg_dst;
    assign MemtoReg     = ctrl.mem_to_reg;
    assign RegWrite     = ctrl.reg_write;
    assign ALUSrcA      = ctrl.alu_src_a;
    assign ALUSrcB      = ctrl.alu_src_b;
    assign PCSource     = ctrl.pc_source;
    assign ALUOp        = ctrl.alu_op;
    assign Illegal      = ctrl.illegal;
    assign RetiredCount = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: each issued instruction pushes an expected per-instruction
// profile; a monitor splits the output stream at FETCH entries and compares.
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Opcode, Funct;
    logic          Zero, MemReady;
    logic          PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0]    ALUSrcB, PCSource;
    logic [2:0]    ALUOp;
    logic [CW-1:0] RetiredCount;

    multicycle_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal),
        .RetiredCount(RetiredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cycles, n_rd, n_wr, n_rw, n_pcw, n_irw, n_ill, n_sub;
        logic          saw_r, wb_dst, wb_m2r, ret;
        logic [2:0]    wb_op, ex_op;
        logic [1:0]    br_src;
        logic [CW-1:0] cnt;
        logic          chk_wb, chk_wbop, chk_ex, chk_br;
    } rec_t;

    rec_t          q[$];
    int            n_cmp = 0, n_bad = 0, n_rec = 0;
    logic [CW-1:0] exp_cnt = '0;
    bit            mon_en = 1'b1;
    logic [5:0]    legal_fn [7] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000, 6'b000010};
    logic [5:0]    legal_op [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit fn_ok(input logic [5:0] fn);
        foreach (legal_fn[i]) if (legal_fn[i] == fn) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        foreach (legal_op[i]) if (legal_op[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected profile of one instruction, from the per-class latencies and strobe rules.
    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                   input int wf, input int wm);
        rec_t e = '{default: 0};
        int   base = wf + 2;
        e.n_rd = wf + 1; e.n_pcw = 1; e.n_irw = 1;
        case (op)
            6'h00: begin
                e.saw_r = 1'b1;
                if (fn_ok(fn)) begin
                    e.cycles = base + 2; e.n_rw = 1; e.wb_dst = 1'b1; e.chk_wb = 1'b1; e.ret = 1'b1;
                end else begin
                    e.cycles = base + 1; e.n_ill = 1;
                end
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                e.cycles = base + 2; e.n_rw = 1; e.chk_wb = 1'b1; e.chk_wbop = 1'b1; e.chk_ex = 1'b1; e.ret = 1'b1;
                e.ex_op = (op == 6'h08) ? 3'b100 : (op == 6'h0C) ? 3'b000 : (op == 6'h0D) ? 3'b001 : 3'b101;
                e.wb_op = e.ex_op;
            end
            6'h23: begin
                e.cycles = base + wm + 3; e.n_rd += wm + 1; e.n_rw = 1; e.wb_m2r = 1'b1;
                e.chk_wb = 1'b1; e.ex_op = 3'b100; e.chk_ex = 1'b1; e.ret = 1'b1;
            end
            6'h2B: begin
                e.cycles = base + wm + 2; e.n_wr = wm + 1; e.ex_op = 3'b100; e.chk_ex = 1'b1; e.ret = 1'b1;
            end
            6'h04, 6'h05: begin
                e.cycles = base + 1; e.n_sub = 1; e.br_src = 2'b01; e.chk_br = 1'b1; e.ret = 1'b1;
                e.n_pcw += ((op == 6'h04) ? z : !z) ? 1 : 0;
            end
            6'h02: begin
                e.cycles = base + 1; e.n_pcw += 1; e.ret = 1'b1;
            end
            default: begin
                e.cycles = base; e.n_ill = 1;
            end
        endcase
        return e;
    endfunction

    task automatic step(input logic mr);
        MemReady = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z, input int wf, input int wm);
        rec_t e;
        Opcode = op; Funct = fn; Zero = z;
        e = model(op, fn, z, wf, wm);
        if (e.ret) exp_cnt = exp_cnt + 1'b1;
        e.cnt = exp_cnt;
        q.push_back(e);
        repeat (wf) step(1'b0);
        step(1'b1);
        step(1'($urandom_range(0, 1)));
        if (op == 6'h23 || op == 6'h2B) begin
            step(1'($urandom_range(0, 1)));
            repeat (wm) step(1'b0);
            step(1'b1);
            if (op == 6'h23) step(1'($urandom_range(0, 1)));
        end else begin
            repeat (e.cycles - wf - 2) step(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic close_rec(input rec_t a);
        rec_t  e;
        string t;
        n_rec++;
        if (q.size() == 0) begin
            check("unexpected_instr", 1, 0);
            return;
        end
        e = q.pop_front();
        t = $sformatf("i%0d", n_rec);
        check({t, "_cycles"}, a.cycles, e.cycles);
        check({t, "_memread"}, a.n_rd, e.n_rd);
        check({t, "_memwrite"}, a.n_wr, e.n_wr);
        check({t, "_regwrite"}, a.n_rw, e.n_rw);
        check({t, "_pcwrite"}, a.n_pcw, e.n_pcw);
        check({t, "_irwrite"}, a.n_irw, e.n_irw);
        check({t, "_illegal"}, a.n_ill, e.n_ill);
        check({t, "_sub"}, a.n_sub, e.n_sub);
        check({t, "_rtype_op"}, a.saw_r, e.saw_r);
        check({t, "_retired"}, a.cnt, e.cnt);
        if (e.chk_wb)   begin check({t, "_regdst"}, a.wb_dst, e.wb_dst); check({t, "_memtoreg"}, a.wb_m2r, e.wb_m2r); end
        if (e.chk_wbop) check({t, "_wb_aluop"}, a.wb_op, e.wb_op);
        if (e.chk_ex)   check({t, "_ex_aluop"}, a.ex_op, e.ex_op);
        if (e.chk_br)   check({t, "_pcsource"}, a.br_src, e.br_src);
    endtask

    initial begin : monitor
        rec_t cur;
        bit   open, prev_f, f;
        open = 0; prev_f = 0; cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                open = 0; prev_f = 0;
                continue;
            end
            check("rd_wr_excl", MemRead & MemWrite, 0);
            check("rw_pcw_excl", RegWrite & PCWrite, 0);
            f = MemRead && !IorD;
            if (f && !prev_f) begin
                if (open) begin
                    cur.cnt = RetiredCount;
                    close_rec(cur);
                end
                cur = '{default: 0};
                open = 1;
            end
            prev_f = f;
            if (open) begin
                cur.cycles++;
                cur.n_rd  += int'(MemRead);
                cur.n_wr  += int'(MemWrite);
                cur.n_rw  += int'(RegWrite);
                cur.n_pcw += int'(PCWrite);
                cur.n_irw += int'(IRWrite);
                cur.n_ill += int'(Illegal);
                cur.n_sub += int'(ALUOp == 3'b010);
                if (ALUOp == 3'b111) cur.saw_r = 1'b1;
                if (RegWrite) begin cur.wb_dst = RegDst; cur.wb_m2r = MemtoReg; cur.wb_op = ALUOp; end
                if (ALUSrcA && ALUSrcB == 2'b10) cur.ex_op = ALUOp;
                if (ALUOp == 3'b010) cur.br_src = PCSource;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] strobes();
        return {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSource, Illegal};
    endfunction

    initial begin : stim
        logic [5:0] op, fn;
        reset = 1'b1; Opcode = '0; Funct = '0; Zero = 1'b0; MemReady = 1'b0;
        @(negedge clk);
        check("reset_strobes", strobes(), 0);
        check("reset_aluop", ALUOp, 3'b100);
        check("reset_count", RetiredCount, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        issue(6'h00, 6'b100000, 1'b0, 0, 0);   // ADD
        issue(6'h23, 6'h00, 1'b0, 0, 3);       // LW, 3 wait cycles
        issue(6'h04, 6'h00, 1'b1, 0, 0);       // BEQ taken
        issue(6'h05, 6'h00, 1'b1, 0, 0);       // BNE not taken
        issue(6'h0D, 6'h00, 1'b0, 0, 0);       // ORI
        issue(6'h0F, 6'h00, 1'b0, 0, 0);       // LUI
        issue(6'h3F, 6'h00, 1'b0, 0, 0);       // illegal opcode
        issue(6'h00, 6'b001000, 1'b0, 0, 0);   // illegal funct
        issue(6'h2B, 6'h00, 1'b0, 1, 2);       // SW with waits

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 11))
                0:  begin op = 6'h00; fn = legal_fn[$urandom_range(0, 6)]; end
                1:  begin op = 6'h00; do fn = 6'($urandom); while (fn_ok(fn)); end
                2:  begin op = 6'h08; fn = 6'($urandom); end
                3:  begin op = 6'h0C; fn = 6'($urandom); end
                4:  begin op = 6'h0D; fn = 6'($urandom); end
                5:  begin op = 6'h0F; fn = 6'($urandom); end
                6:  begin op = 6'h23; fn = 6'($urandom); end
                7:  begin op = 6'h2B; fn = 6'($urandom); end
                8:  begin op = 6'h04; fn = 6'($urandom); end
                9:  begin op = 6'h05; fn = 6'($urandom); end
                10: begin op = 6'h02; fn = 6'($urandom); end
                default: begin do op = 6'($urandom); while (op_ok(op)); fn = 6'($urandom); end
            endcase
            issue(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Park in FETCH so the monitor closes the last record, then stop scoring.
        Opcode = 6'h2B;
        step(1'b0);
        step(1'b0);
        mon_en = 1'b0;
        check("queue_drained", q.size(), 0);

        // SW into MEM_WR wait, then reset mid-wait.
        step(1'b1);
        step(1'b0);
        step(1'b0);
        MemReady = 1'b0;
        @(negedge clk);
        check("memwr_wait", MemWrite, 1);
        check("count_before_reset", RetiredCount, exp_cnt);
        #1 reset = 1'b1;
        #1;
        check("async_memwrite_drop", MemWrite, 0);
        check("async_strobes", strobes(), 0);
        check("async_count", RetiredCount, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_fetch", {MemRead, IorD, ALUSrcB}, 4'b1001);
        check("post_reset_count", RetiredCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
